sclk_period_meter: RTL and testbench

Measures the slow clock produced by the design's clock divider, in cycles of the fast system clock. It synchronises `sclk_in`, detects its edges, and reports the period and high time of each full cycle with a one-cycle valid strobe. It also raises a lock indication once the rate is stable and a timeout flag if `sclk_in` stops toggling. It sits beside the divider and is the self-check that game logic and the bench use to confirm the reel/step rate.

---
 rtl/sclk_period_meter.sv | 153 +++++++++++++++
 tb/tb_sclk_period_meter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sclk_period_meter.sv
// sclk_period_meter
// Measures the period and high time of the slow divider clock sclk_in in
// cycles of clk. sclk_in is synchronised and edge-detected; each complete
// rise-to-rise cycle produces a one-cycle period_valid strobe together with
// the updated period/high_time. locked reports two consecutive equal
// periods, and the sticky timeout flag reports a stalled sclk_in.
module sclk_period_meter #(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + CNT_ONE;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_reg;
  logic [CNT_W-1:0] prev;
  logic             prev_ok;
  logic             fall_seen;

  logic             s1, s2, s3;
  logic             rise, fall;

  // Three-flop synchroniser; s3 is the delayed copy used for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sclk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Measurement FSM: counts clk cycles between detected edges and drives
  // all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_reg       <= '0;
      prev         <= '0;
      prev_ok      <= 1'b0;
      fall_seen    <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!enable) begin
        // Disabled: drop any partial measurement but keep the last result.
        state     <= IDLE;
        cnt       <= '0;
        hi_reg    <= '0;
        prev      <= '0;
        prev_ok   <= 1'b0;
        fall_seen <= 1'b0;
        locked    <= 1'b0;
        timeout   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT_FIRST;
            cnt   <= '0;
          end

          WAIT_FIRST: begin
            if (rise) begin
              // First rise only arms the measurement.
              state     <= MEASURE;
              cnt       <= CNT_ONE;
              hi_reg    <= '0;
              fall_seen <= 1'b0;
            end else if (cnt >= TO_VAL) begin
              timeout <= 1'b1;
              locked  <= 1'b0;
              prev_ok <= 1'b0;
              cnt     <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end

          MEASURE: begin
            if (rise) begin
              // A rise coinciding with the timeout count still completes.
              period       <= cnt;
              high_time    <= hi_reg;
              period_valid <= 1'b1;
              timeout      <= 1'b0;
              cnt          <= CNT_ONE;
              fall_seen    <= 1'b0;
              prev         <= cnt;
              locked       <= (cnt == prev) && prev_ok;
              prev_ok      <= 1'b1;
            end else if (cnt >= TO_VAL) begin
              state   <= WAIT_FIRST;
              timeout <= 1'b1;
              locked  <= 1'b0;
              prev_ok <= 1'b0;
              cnt     <= '0;
            end else begin
              cnt <= sat_inc(cnt);
              if (fall && !fall_seen) begin
                hi_reg    <= cnt;
                fall_seen <= 1'b1;
              end
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sclk_period_meter.sv
// Testbench for sclk_period_meter: directed vector table, hand-written
// corner sequences and randomized sclk_in shapes, all compared against a
// timestamp-based reference model.
module tb_sclk_period_meter;

  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 100;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sclk_in = 1'b0;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  sclk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .sclk_in      (sclk_in),
    .enable       (enable),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (edge timestamps) ----------------
  int  t_now = 0, t_rise = 0, t_arm = 0, m_hi = 0;
  bit  m_on = 0, m_meas = 0, m_fell = 0;
  int  exp_period = 0, exp_high = 0;
  bit  exp_valid = 0, exp_locked = 0, exp_timeout = 0;
  int  q_per[$];
  bit  smp[$];
  bit  r_det, f_det;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_on = 0; m_meas = 0; m_fell = 0; m_hi = 0;
        exp_period = 0; exp_high = 0; exp_valid = 0;
        exp_locked = 0; exp_timeout = 0;
        q_per.delete();
        smp.delete();
        repeat (3) smp.push_back(1'b0);
      end else begin
        t_now++;
        // sclk_in becomes visible to edge detection two samples later
        r_det = smp[smp.size()-2] & ~smp[smp.size()-3];
        f_det = ~smp[smp.size()-2] & smp[smp.size()-3];
        exp_valid = 0;
        if (!enable) begin
          m_on = 0; m_meas = 0; exp_locked = 0; exp_timeout = 0;
          q_per.delete();
        end else if (!m_on) begin
          m_on = 1; t_arm = t_now;
        end else if (!m_meas) begin
          if (r_det) begin
            m_meas = 1; t_rise = t_now; m_fell = 0; m_hi = 0;
          end else if (t_now - t_arm == TIMEOUT + 1) begin
            exp_timeout = 1; exp_locked = 0; q_per.delete(); t_arm = t_now;
          end
        end else begin
          if (r_det) begin
            exp_period = t_now - t_rise;
            exp_high   = m_hi;
            exp_valid  = 1;
            exp_timeout = 0;
            q_per.push_back(exp_period);
            exp_locked = (q_per.size() >= 2) && (q_per[q_per.size()-1] == q_per[q_per.size()-2]);
            t_rise = t_now; m_fell = 0;
          end else if (t_now - t_rise == TIMEOUT) begin
            exp_timeout = 1; exp_locked = 0; q_per.delete();
            m_meas = 0; t_arm = t_now;
          end else if (f_det && !m_fell) begin
            m_hi = t_now - t_rise; m_fell = 1;
          end
        end
        smp.push_back(sclk_in);
        if (smp.size() > 4) void'(smp.pop_front());
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("period",       32'(period),       32'(exp_period));
      chk("high_time",    32'(high_time),    32'(exp_high));
      chk("period_valid", 32'(period_valid), 32'(exp_valid));
      chk("locked",       32'(locked),       32'(exp_locked));
      chk("timeout",      32'(timeout),      32'(exp_timeout));
    end
  end

  // Capture of the most recent valid result for the directed checks.
  int vcnt = 0;
  logic [CNT_W-1:0] cap_period = '0, cap_high = '0;
  logic             cap_locked = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (period_valid === 1'b1) begin
        vcnt++;
        cap_period = period;
        cap_high   = high_time;
        cap_locked = locked;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    int hi;
    int lo;
    bit vld;
    int per;
    int hti;
    bit lck;
  } vec_t;

  vec_t tbl[10];
  int   v0;
  int   hi_r, lo_r;

  initial begin
    // Each row drives one sclk cycle; its rise completes the previous row's cycle.
    tbl[0] = '{11, 11, 1'b0,  0,  0, 1'b0};
    tbl[1] = '{11, 11, 1'b1, 22, 11, 1'b0};
    tbl[2] = '{11, 11, 1'b1, 22, 11, 1'b1};
    tbl[3] = '{11, 11, 1'b1, 22, 11, 1'b1};
    tbl[4] = '{ 5, 17, 1'b1, 22, 11, 1'b1};
    tbl[5] = '{ 5, 17, 1'b1, 22,  5, 1'b1};
    tbl[6] = '{ 5, 20, 1'b1, 22,  5, 1'b1};
    tbl[7] = '{ 5, 20, 1'b1, 25,  5, 1'b0};
    tbl[8] = '{ 5, 20, 1'b1, 25,  5, 1'b1};
    tbl[9] = '{11, 11, 1'b1, 25,  5, 1'b1};

    // Reset state
    tick(3);
    chk("rst_period", 32'(period), 0);
    chk("rst_valid",  32'(period_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_timeout", 32'(timeout), 0);
    #2 reset = 1'b1;
    tick(2);
    enable = 1'b1;
    tick(5);

    // Directed table: steady 11/11, duty change, period change and re-lock
    for (int i = 0; i < 10; i++) begin
      v0 = vcnt;
      sclk_in = 1'b1;
      tick(tbl[i].hi);
      chk($sformatf("tbl%0d_nvalid", i), 32'(vcnt - v0), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_period", i), 32'(cap_period), 32'(tbl[i].per));
        chk($sformatf("tbl%0d_high", i),   32'(cap_high),   32'(tbl[i].hti));
        chk($sformatf("tbl%0d_locked", i), 32'(cap_locked), 32'(tbl[i].lck));
      end
      sclk_in = 1'b0;
      tick(tbl[i].lo);
    end

    // Stall after a rise: timeout exactly TIMEOUT cycles after the rise is acted on
    v0 = vcnt;
    sclk_in = 1'b1;
    tick(5);
    chk("stall_valid",  32'(vcnt - v0), 1);
    chk("stall_period", 32'(cap_period), 22);
    tick(97);
    chk("stall_to_early", 32'(timeout), 0);
    tick(1);
    chk("stall_to",     32'(timeout), 1);
    chk("stall_locked", 32'(locked), 0);
    chk("stall_hold",   32'(period), 22);
    // Resume: first rise only re-arms, second rise clears timeout
    sclk_in = 1'b0; tick(11);
    v0 = vcnt;
    sclk_in = 1'b1; tick(5);
    chk("resume_r1_to",    32'(timeout), 1);
    chk("resume_r1_valid", 32'(vcnt - v0), 0);
    tick(6);
    sclk_in = 1'b0; tick(11);
    sclk_in = 1'b1; tick(5);
    chk("resume_r2_valid", 32'(vcnt - v0), 1);
    chk("resume_r2_to",    32'(timeout), 0);
    chk("resume_r2_per",   32'(period), 22);

    // Rise coincident with cnt == TIMEOUT completes normally
    tick(6);
    sclk_in = 1'b0; tick(11);
    sclk_in = 1'b1; tick(50);
    sclk_in = 1'b0; tick(50);
    v0 = vcnt;
    sclk_in = 1'b1; tick(5);
    chk("coinc_valid",  32'(vcnt - v0), 1);
    chk("coinc_period", 32'(cap_period), 100);
    chk("coinc_to",     32'(timeout), 0);
    // One cycle longer: timeout wins, next rise only arms
    tick(45);
    sclk_in = 1'b0; tick(51);
    v0 = vcnt;
    sclk_in = 1'b1; tick(5);
    chk("over_to",    32'(timeout), 1);
    chk("over_valid", 32'(vcnt - v0), 0);
    tick(45);
    sclk_in = 1'b0; tick(20);

    // Enable dropped mid-period
    repeat (4) begin
      sclk_in = 1'b1; tick(10);
      sclk_in = 1'b0; tick(10);
    end
    chk("pre_dis_locked", 32'(locked), 1);
    sclk_in = 1'b1; tick(7);
    v0 = vcnt;
    enable = 1'b0; tick(1);
    chk("dis_locked", 32'(locked), 0);
    chk("dis_to",     32'(timeout), 0);
    tick(2);
    sclk_in = 1'b0; tick(10);
    repeat (3) begin
      sclk_in = 1'b1; tick(10);
      sclk_in = 1'b0; tick(10);
    end
    chk("dis_valid", 32'(vcnt - v0), 0);
    enable = 1'b1;
    sclk_in = 1'b1; tick(5);
    chk("reen_r1_valid", 32'(vcnt - v0), 0);
    tick(5);
    sclk_in = 1'b0; tick(10);
    sclk_in = 1'b1; tick(5);
    chk("reen_r2_valid",  32'(vcnt - v0), 1);
    chk("reen_r2_period", 32'(cap_period), 20);
    tick(5);
    sclk_in = 1'b0; tick(10);

    // Asynchronous reset mid-measure, released with sclk_in high
    sclk_in = 1'b1; tick(7);
    #2 reset = 1'b0;
    #1;
    chk("arst_period", 32'(period), 0);
    chk("arst_high",   32'(high_time), 0);
    chk("arst_valid",  32'(period_valid), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_to",     32'(timeout), 0);
    tick(3);
    #2 reset = 1'b1;
    v0 = vcnt;
    tick(120);
    chk("rel_spurious_valid", 32'(vcnt - v0), 0);
    sclk_in = 1'b0; tick(10);
    sclk_in = 1'b1; tick(5);
    chk("rel_r1_valid", 32'(vcnt - v0), 0);
    tick(5);
    sclk_in = 1'b0; tick(10);
    sclk_in = 1'b1; tick(5);
    chk("rel_r2_valid",  32'(vcnt - v0), 1);
    chk("rel_r2_period", 32'(cap_period), 20);
    tick(5);
    sclk_in = 1'b0; tick(10);

    // Randomized shapes, including periods around the timeout and enable drops
    repeat (80) begin
      hi_r = $urandom_range(1, 40);
      lo_r = $urandom_range(1, 40);
      if ($urandom_range(0, 9) == 0) lo_r = $urandom_range(95, 110);
      sclk_in = 1'b1; tick(hi_r);
      sclk_in = 1'b0; tick(lo_r);
      if ($urandom_range(0, 14) == 0) begin
        enable = 1'b0;
        tick($urandom_range(1, 20));
        enable = 1'b1;
      end
    end

    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
